// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int OPCODE_W  = 8;
  localparam int OPERAND_W = 8;

  // Field positions inside the 16-bit ROM word.
  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 8;
  localparam int OPERAND_MSB = 7;
  localparam int OPERAND_LSB = 0;

  localparam logic [OPCODE_W-1:0] HALT_OP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    HOLD,
    REDIRECT,
    HALT
  } fetch_state_t;

  // True when the opcode stops fetching.
  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_reg.sv
// Instruction holding register: splits the ROM word into opcode and operand
// and keeps them until the next load.
module instr_reg
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [INSTR_W-1:0]   data_i,
  output logic [OPCODE_W-1:0]  opcode_o,
  output logic [OPERAND_W-1:0] operand_o
);

  logic [OPCODE_W-1:0]  opcode_q,  opcode_d;
  logic [OPERAND_W-1:0] operand_q, operand_d;

  // Select new contents when loading, otherwise hold.
  always_comb begin
    opcode_d  = opcode_q;
    operand_d = operand_q;
    if (load_i) begin
      opcode_d  = data_i[OPCODE_MSB:OPCODE_LSB];
      operand_d = data_i[OPERAND_MSB:OPERAND_LSB];
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch controller: sequences PC increment/load, captures the ROM word one
// cycle after the address is presented, and offers it to decode over
// valid/ready. Branch redirects from execute discard any in-flight fetch.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    PC_address,
  input  logic [INSTR_W-1:0]   rom_data,
  output logic                 reg_inc,
  output logic                 reg_load,
  output logic [ADDR_W-1:0]    reg_input,
  input  logic                 jump_req,
  input  logic [ADDR_W-1:0]    jump_target,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [OPCODE_W-1:0]  instr_opcode,
  output logic [OPERAND_W-1:0] instr_operand,
  output logic [ADDR_W-1:0]    instr_pc,
  output logic                 halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              jump_hit;
  logic              ir_load;

  // A redirect is honoured only while a fetch is in progress or held.
  always_comb begin
    jump_hit = jump_req && (state_q inside {FETCH, LATCH, HOLD});
  end

  // Next-state logic; a redirect always wins over the normal sequence.
  always_comb begin
    // NOTE: defaulting every output of a combinational block first keeps it
    // free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (run) state_d = FETCH;
      FETCH:    state_d = jump_hit ? REDIRECT : LATCH;
      LATCH:    state_d = jump_hit ? REDIRECT : HOLD;
      HOLD: begin
        if (jump_hit) begin
          state_d = REDIRECT;
        end else if (instr_ready) begin
          state_d = is_halt(instr_opcode) ? HALT : FETCH;
        end
      end
      REDIRECT: state_d = FETCH;
      HALT:     if (!run) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // PC control and handshake outputs, decoded from state and the redirect.
  always_comb begin
    reg_load    = jump_hit;
    reg_input   = jump_hit ? jump_target : '0;
    reg_inc     = (state_q == LATCH) && !jump_hit;
    ir_load     = (state_q == LATCH) && !jump_hit;
    instr_valid = (state_q == HOLD);
    halted      = (state_q == HALT);
  end

  // Remember the address the ROM is sampling; a redirected fetch is dropped.
  always_comb begin
    pc_d = pc_q;
    if ((state_q == FETCH) && !jump_hit) pc_d = PC_address;
  end

  // Fetch-address register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign instr_pc = pc_q;

  instr_reg #(
    .INSTR_W (INSTR_W)
  ) u_instr_reg (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load_i    (ir_load),
    .data_i    (rom_data),
    .opcode_o  (instr_opcode),
    .operand_o (instr_operand)
  );

endmodule
